uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter; the transmit-side counterpart of the block's UART receiver.
- Sits between the TX FIFO read side (AXI-Lite controller) and the `tx` pin.
- Frames one byte per request as: start bit, 8 data bits LSB-first, optional parity bit, stop bit.
- Bit timing derives from the shared 16x-oversampling baud tick `b_tick`.

Parameters:
- TICKS_PER_BIT, 16, b_tick pulses per serial bit; must match the receiver oversampling.
- STOP_TICKS, 16, b_tick pulses in one stop bit.

Ports:
- clk  input  1  system clock.
- a_resetn  input  1  asynchronous, active-low reset.
- b_tick  input  1  one-clk-wide baud oversample strobe (16x baud).
- parity  input  2  00 none, 01 odd, 10 even, 11 reserved (treated as none).
- tx_start  input  1  request to send `din`; level-sampled.
- din  input  8  byte to transmit.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset (asynchronous, a_resetn low): state=IDLE, tx=1, tx_busy=0, tx_done=0, tick counter=0, bit index=0, shift register=0, parity latch=00.
- FSM states: IDLE, START, DATA, PARITY, STOP. Encoding comes from the package.
- IDLE:
  - tx=1, tx_busy=0, tick counter=0.
  - If tx_start=1: latch din into the shift register, latch parity, compute the parity bit, go to START.
  - The parity bit is ~^din for odd and ^din for even.
  - Latency: tx_start at cycle N gives tx=0 and tx_busy=1 at cycle N+1.
- Request handling:
  - tx_start is ignored in every state except IDLE.
  - din and parity changes after acceptance do not affect the frame in flight.
- Bit timing (START, DATA, PARITY):
  - The counter increments only on b_tick.
  - On a b_tick with counter==TICKS_PER_BIT-1: counter←0 and the bit advances.
  - With no b_tick, the state and counter hold.
  - Each bit therefore lasts exactly TICKS_PER_BIT b_ticks.
- START: tx=0. After TICKS_PER_BIT ticks, go to DATA with bit index=0.
- DATA:
  - tx=shift[bit index].
  - At the end of each bit, bit index+1.
  - After bit 7, go to PARITY if the latched parity is 01 or 10; otherwise go to STOP.
- PARITY: tx=parity bit for TICKS_PER_BIT ticks, then go to STOP.
- STOP:
  - tx=1 for STOP_TICKS ticks.
  - On the final tick: tx_done=1 for one cycle, state←IDLE.
- Back-to-back frames:
  - tx_start high in the cycle tx_done is asserted is sampled in IDLE on the next cycle.
  - Minimum gap between frames is therefore 1 clk beyond the stop bit.
- tx_busy=1 in START/DATA/PARITY/STOP and 0 in IDLE, including the tx_done cycle's next state.
- Mid-frame reset: the line returns to 1 immediately (asynchronous); the partial frame is abandoned and no tx_done pulse is issued.
- tx is driven from a flop (registered); no combinational path from inputs to tx.
- Counter width: $clog2(max(TICKS_PER_BIT, 2*STOP_TICKS)) bits; no wrap beyond the terminal count.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*STOP_TICKS b_ticks (two stop bits); tx_done fires at the end of the second stop bit.
- Undefined: one stop bit of STOP_TICKS ticks.
- The receiver remains compatible either way, since it checks only the first stop bit.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP; 3-bit, shared encoding with the receiver);
  - parity constants PARITY_NONE=2'b00, PARITY_ODD=2'b01, PARITY_EVEN=2'b10;
  - TICKS_PER_BIT default 16.
- No sub-module. The baud tick generator is an existing separate block shared with RX and is not instantiated here.

Test Plan:
- Run with b_tick every clk.
- Frame 0x55, parity=00: after tx_start, tx holds each value for 16 clks in the order 0,1,0,1,0,1,0,1,0,1. tx_done pulses at clk 160 after acceptance. tx_busy is high for clks 1–160.
- Frame 0xA5, even parity: parity bit 0. Same byte with odd parity: parity bit 1. Frame 0x07, even parity: parity bit 1. Each frame is 176 clks.
- Pulse tx_start with 0x3C while busy mid-frame: the request is ignored, the current frame completes unchanged, and no second tx_done appears.
- Assert a_resetn low during DATA bit 3: tx=1, tx_busy=0 immediately. After release, a new tx_start with 0x81 produces a clean frame.
- Loopback into UART_RX with a b_tick every 4 clks, all 3 parity modes, bytes 0x00, 0xFF, 0x5A:
  - RX dout equals the sent byte and rx_done pulses once per frame;
  - back-to-back frames (tx_start held high) show no lost bytes.
- With UART_TX_TWO_STOP_EN defined: a 0x55 no-parity frame keeps the stop level at 1 for 32 clks, and tx_done pulses at clk 176.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   - uart_state_e : frame FSM states (encoding shared with the receiver)
//   - PARITY_*     : encodings of the 2-bit parity mode input
//   - TICKS_PER_BIT: default number of 16x baud ticks per serial bit
//   - parity_bit() / parity_enabled(): parity helpers
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam int TICKS_PER_BIT = 16;

    // Parity bit appended to the frame; only meaningful when parity_enabled().
    function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

    // The reserved mode 2'b11 behaves like PARITY_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_ODD) || (mode == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter. Frames one byte per accepted request as
// start bit, 8 data bits LSB first, optional parity bit, stop bit(s).
// Bit timing is counted in pulses of the shared 16x oversampling tick.
//
// Build option:
//   UART_TX_TWO_STOP_EN  defined  -> two stop bits (2*STOP_TICKS ticks)
//                        undefined-> one stop bit (STOP_TICKS ticks)
//
// Ports:
//   clk       in   system clock
//   a_resetn  in   asynchronous active-low reset
//   b_tick    in   one-clk baud oversample strobe
//   parity    in   [1:0] 00 none, 01 odd, 10 even, 11 none
//   tx_start  in   send request, level-sampled, honoured only when idle
//   din       in   [7:0] byte to send
//   tx        out  serial line, idle high, registered
//   tx_busy   out  high while a frame is in progress
//   tx_done   out  one-clk pulse after the last stop tick
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int TICKS_PER_BIT = uart_pkg::TICKS_PER_BIT,
    parameter int STOP_TICKS    = 16
) (
    input  logic       clk,
    input  logic       a_resetn,
    input  logic       b_tick,
    input  logic [1:0] parity,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    import uart_pkg::*;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_LEN = 2 * STOP_TICKS;
`else
    localparam int STOP_LEN = STOP_TICKS;
`endif

    // Sized for the longest interval that can ever be counted (two stop bits).
    localparam int CNT_MAX = (TICKS_PER_BIT > 2 * STOP_TICKS) ? TICKS_PER_BIT : 2 * STOP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(TICKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LEN - 1);

    uart_state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [1:0]       r_parity;
    logic             r_parity_bit;
    logic             r_tx;
    logic             r_tx_done;

    uart_state_e      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic [1:0]       w_parity_nxt;
    logic             w_parity_bit_nxt;
    logic             w_tx_nxt;
    logic             w_tx_done_nxt;
    logic             w_bit_end;

    assign w_bit_end = b_tick && (r_cnt == BIT_LAST);

    // Next-state logic for the frame FSM and its datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_parity_nxt     = r_parity;
        w_parity_bit_nxt = r_parity_bit;
        w_tx_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (tx_start) begin
                    w_shift_nxt      = din;
                    w_parity_nxt     = parity;
                    w_parity_bit_nxt = parity_bit(din, parity);
                    w_state_nxt      = START;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = DATA;
                end else if (b_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = parity_enabled(r_parity) ? PARITY : STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else if (b_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            PARITY: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = STOP;
                end else if (b_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            STOP: begin
                if (b_tick && (r_cnt == STOP_LAST)) begin
                    w_cnt_nxt     = '0;
                    w_tx_done_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else if (b_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase

        // Line level is decoded from the state being entered, so the tx flop
        // changes on the same edge as the FSM and the start bit appears one
        // clk after acceptance.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
            PARITY:  w_tx_nxt = w_parity_bit_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= PARITY_NONE;
            r_parity_bit <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_parity     <= w_parity_nxt;
            r_parity_bit <= w_parity_bit_nxt;
            r_tx         <= w_tx_nxt;
            r_tx_done    <= w_tx_done_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;
    assign tx_busy = (r_state != IDLE);

endmodule
